// File: rtl/mem_access_stage.sv
// mem_access_stage
// Pipeline MEM stage. Consumes EX/MEM register outputs, turns each legal
// load/store into a req/ack transaction on the data-memory port, stalls
// upstream while a transaction is outstanding and registers the MEM/WB values.
// Non-memory instructions pass through with one cycle of latency.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   valid                 EX/MEM holds a live instruction
//   mem_read, mem_write   load / store controls
//   write_reg, write_back register-file write enable / write-back source select
//   ALU_output            effective address or ALU result
//   readData2             store data
//   rt_or_rd              destination register index
//   stall                 combinational hold request to EX/MEM and earlier
//   dmem_req/we/addr/wdata registered data-memory request
//   dmem_ack, dmem_rdata  memory completion strobe and load data
//   o_*                   registered MEM/WB pipeline values, o_exc = memory exception
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              write_reg,
  input  logic              write_back,
  input  logic [DATA_W-1:0] ALU_output,
  input  logic [DATA_W-1:0] readData2,
  input  logic [REG_W-1:0]  rt_or_rd,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              o_valid,
  output logic              o_write_reg,
  output logic              o_write_back,
  output logic [DATA_W-1:0] o_ALU_output,
  output logic [DATA_W-1:0] o_mem_data,
  output logic [REG_W-1:0]  o_rt_or_rd,
  output logic              o_exc
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // An access is an exception when misaligned or when read and write are both set.
  function automatic logic access_exc(input logic rd, input logic wr, input logic [1:0] lsb);
    return (lsb != 2'b00) | (rd & wr);
  endfunction

  state_t state_r, state_s;

  logic              access_s, exc_s, stall_s;
  logic              req_s, we_s;
  logic [DATA_W-1:0] addr_s, wdata_s;

  // Instruction held while its transaction is outstanding
  logic              lat_read_r, lat_read_s;
  logic              lat_write_reg_r, lat_write_reg_s;
  logic              lat_write_back_r, lat_write_back_s;
  logic [DATA_W-1:0] lat_alu_r, lat_alu_s;
  logic [REG_W-1:0]  lat_rd_r, lat_rd_s;

  logic              ov_s, owr_s, owb_s, oexc_s;
  logic [DATA_W-1:0] oalu_s, omd_s;
  logic [REG_W-1:0]  ord_s;

  assign access_s = valid & (mem_read | mem_write);
  assign exc_s    = access_s & access_exc(mem_read, mem_write, ALU_output[1:0]);
  // Stall depends on the live state, but is forced low throughout reset.
  assign stall    = rst_n & stall_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, stall and next values for every registered output
  always_comb begin
    state_s          = state_r;
    stall_s          = 1'b0;
    req_s            = dmem_req;
    we_s             = dmem_we;
    addr_s           = dmem_addr;
    wdata_s          = dmem_wdata;
    lat_read_s       = lat_read_r;
    lat_write_reg_s  = lat_write_reg_r;
    lat_write_back_s = lat_write_back_r;
    lat_alu_s        = lat_alu_r;
    lat_rd_s         = lat_rd_r;
    ov_s             = 1'b0;
    owr_s            = 1'b0;
    oexc_s           = 1'b0;
    owb_s            = o_write_back;
    oalu_s           = o_ALU_output;
    omd_s            = o_mem_data;
    ord_s            = o_rt_or_rd;
    case (state_r)
      IDLE: begin
        if (access_s && !exc_s) begin
          // Launch the request; MEM/WB receives a bubble meanwhile.
          stall_s          = 1'b1;
          state_s          = WAIT;
          req_s            = 1'b1;
          we_s             = mem_write;
          addr_s           = ALU_output;
          wdata_s          = readData2;
          lat_read_s       = mem_read;
          lat_write_reg_s  = write_reg;
          lat_write_back_s = write_back;
          lat_alu_s        = ALU_output;
          lat_rd_s         = rt_or_rd;
        end else begin
          // Pass-through, bubble or exception; a stray ack here is ignored.
          ov_s   = valid;
          owr_s  = write_reg & valid & ~exc_s;
          oexc_s = exc_s;
          owb_s  = write_back;
          oalu_s = ALU_output;
          ord_s  = rt_or_rd;
        end
      end
      WAIT: begin
        stall_s = ~dmem_ack;
        if (dmem_ack) begin
          state_s = IDLE;
          req_s   = 1'b0;
          ov_s    = 1'b1;
          owr_s   = lat_write_reg_r;
          owb_s   = lat_write_back_r;
          oalu_s  = lat_alu_r;
          ord_s   = lat_rd_r;
          if (lat_read_r) begin
            omd_s = dmem_rdata;
          end else begin
            omd_s = o_mem_data;
          end
        end else begin
          state_s = WAIT;
          req_s   = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // Memory port, latched instruction and MEM/WB registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      lat_read_r       <= 1'b0;
      lat_write_reg_r  <= 1'b0;
      lat_write_back_r <= 1'b0;
      lat_alu_r        <= '0;
      lat_rd_r         <= '0;
      o_valid          <= 1'b0;
      o_write_reg      <= 1'b0;
      o_write_back     <= 1'b0;
      o_ALU_output     <= '0;
      o_mem_data       <= '0;
      o_rt_or_rd       <= '0;
      o_exc            <= 1'b0;
    end else begin
      dmem_req         <= req_s;
      dmem_we          <= we_s;
      dmem_addr        <= addr_s;
      dmem_wdata       <= wdata_s;
      lat_read_r       <= lat_read_s;
      lat_write_reg_r  <= lat_write_reg_s;
      lat_write_back_r <= lat_write_back_s;
      lat_alu_r        <= lat_alu_s;
      lat_rd_r         <= lat_rd_s;
      o_valid          <= ov_s;
      o_write_reg      <= owr_s;
      o_write_back     <= owb_s;
      o_ALU_output     <= oalu_s;
      o_mem_data       <= omd_s;
      o_rt_or_rd       <= ord_s;
      o_exc            <= oexc_s;
    end
  end

endmodule
